fpga_boot_sequencer: RTL and testbench

FPGA-top controller that sequences bring-up of the x_heep_system instance inside the FPGA wrapper. It waits for the clock wizard to lock and debounces the board reset button. It holds the system reset for a fixed number of cycles, then latches the boot strap pins and releases the system. It also monitors exit_valid/exit_value and drives a status LED.

---
 rtl/fpga_boot_sequencer.sv | 153 +++++++++++++++
 tb/tb_fpga_boot_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_boot_sequencer.sv
// FPGA-top bring-up sequencer for x_heep_system: waits for clock lock, debounces the
// board reset button, holds the system in reset, latches boot straps and reports exit status.
module fpga_boot_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int RST_HOLD_CYCLES = 64,
  parameter int BLINK_W         = 24
) (
  input  logic        clk_gen,
  input  logic        rst_n,
  input  logic        locked_i,
  input  logic        rst_btn_i,
  input  logic        boot_select_i,
  input  logic        execute_from_flash_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        sys_rst_no,
  output logic        boot_select_o,
  output logic        execute_from_flash_o,
  output logic        status_led_o,
  output logic        done_o,
  output logic        exit_bit_o,
  output logic [1:0]  state_o,
  output logic [7:0]  boot_count_o
);
  // state      | meaning
  // WAIT_LOCK  | clock wizard not locked, system in reset
  // RESET_HOLD | counting the reset hold window, system in reset
  // RUN        | system released, waiting for program exit
  // DONE       | program exited, exit bit shown on the LED
  typedef enum logic [1:0] {
    S_WAIT_LOCK  = 2'd0,
    S_RESET_HOLD = 2'd1,
    S_RUN        = 2'd2,
    S_DONE       = 2'd3
  } state_t;

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic lk, btn, bs, eff;
  logic [DB_W-1:0] db_cnt;
  logic db_lvl, btn_db, btn_db_q, btn_rise;
  state_t state, state_d;
  logic [HOLD_W-1:0] hold_cnt;
  logic [BLINK_W-1:0] blink_cnt, blink_d;
  logic run_enter, sys_rst_d, done_d, exit_bit_d, led_d, bs_d, eff_d;
  logic [7:0] count_d;
  logic exit_value_unused;

  assign exit_value_unused = ^exit_value_i[31:1];
  assign {lk, btn, bs, eff} = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= {locked_i, rst_btn_i, boot_select_i, execute_from_flash_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // btn_db re-registers the debounced level so the FSM sees one clean, glitch-free edge
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      db_lvl   <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db   <= db_lvl;
      btn_db_q <= btn_db;
      if (btn == db_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        db_lvl <= btn;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign btn_rise = btn_db & ~btn_db_q;

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state                <= S_WAIT_LOCK;
      hold_cnt             <= '0;
      blink_cnt            <= '0;
      sys_rst_no           <= 1'b0;
      boot_select_o        <= 1'b0;
      execute_from_flash_o <= 1'b0;
      status_led_o         <= 1'b0;
      done_o               <= 1'b0;
      exit_bit_o           <= 1'b0;
      boot_count_o         <= '0;
    end else begin
      state                <= state_d;
      hold_cnt             <= (state != S_RESET_HOLD || btn_db) ? '0 : hold_cnt + 1'b1;
      blink_cnt            <= blink_d;
      sys_rst_no           <= sys_rst_d;
      boot_select_o        <= bs_d;
      execute_from_flash_o <= eff_d;
      status_led_o         <= led_d;
      done_o               <= done_d;
      exit_bit_o           <= exit_bit_d;
      boot_count_o         <= count_d;
    end
  end

  always_comb begin
    state_d = state;
    if (state != S_WAIT_LOCK && !lk) begin
      state_d = S_WAIT_LOCK;
    end else begin
      case (state)
        S_WAIT_LOCK:  if (lk) state_d = S_RESET_HOLD;
        S_RESET_HOLD: if (!btn_db && hold_cnt == HOLD_MAX) state_d = S_RUN;
        S_RUN: begin
          if (btn_rise)          state_d = S_RESET_HOLD;
          else if (exit_valid_i) state_d = S_DONE;
        end
        S_DONE:       if (btn_rise) state_d = S_RESET_HOLD;
        default:      state_d = S_WAIT_LOCK;
      endcase
    end
  end

  // outputs are computed from the next state so they change on the same edge as the state
  always_comb begin
    run_enter  = (state == S_RESET_HOLD) && (state_d == S_RUN);
    blink_d    = blink_cnt + 1'b1;
    sys_rst_d  = (state_d == S_RUN) || (state_d == S_DONE);
    done_d     = (state_d == S_DONE);
    exit_bit_d = 1'b0;
    if (state_d == S_DONE) exit_bit_d = (state == S_DONE) ? exit_bit_o : exit_value_i[0];
    bs_d       = run_enter ? bs : boot_select_o;
    eff_d      = run_enter ? eff : execute_from_flash_o;
    count_d    = (run_enter && boot_count_o != 8'hFF) ? boot_count_o + 8'd1 : boot_count_o;
    case (state_d)
      S_WAIT_LOCK:  led_d = 1'b0;
      S_RESET_HOLD: led_d = 1'b1;
      S_RUN:        led_d = blink_d[BLINK_W-1];
      default:      led_d = exit_bit_d ? blink_d[BLINK_W-3] : 1'b1;
    endcase
  end

  assign state_o = state;
endmodule

// File: tb/tb_fpga_boot_sequencer.sv
// Self-checking bench for fpga_boot_sequencer: directed bring-up scenarios with literal
// expectations, then randomized button/lock/exit traffic against an event-level model.
module tb_fpga_boot_sequencer;
  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int HOLD = 64;
  localparam int BW   = 6;

  logic clk_gen = 1'b0;
  logic rst_n = 1'b0;
  logic locked_i = 1'b0, rst_btn_i = 1'b0, boot_select_i = 1'b0, execute_from_flash_i = 1'b0;
  logic exit_valid_i = 1'b0;
  logic [31:0] exit_value_i = '0;
  logic sys_rst_no, boot_select_o, execute_from_flash_o, status_led_o, done_o, exit_bit_o;
  logic [1:0] state_o;
  logic [7:0] boot_count_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  fpga_boot_sequencer #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .RST_HOLD_CYCLES(HOLD), .BLINK_W(BW)
  ) dut (
    .clk_gen(clk_gen), .rst_n(rst_n), .locked_i(locked_i), .rst_btn_i(rst_btn_i),
    .boot_select_i(boot_select_i), .execute_from_flash_i(execute_from_flash_i),
    .exit_valid_i(exit_valid_i), .exit_value_i(exit_value_i), .sys_rst_no(sys_rst_no),
    .boot_select_o(boot_select_o), .execute_from_flash_o(execute_from_flash_o),
    .status_led_o(status_led_o), .done_o(done_o), .exit_bit_o(exit_bit_o),
    .state_o(state_o), .boot_count_o(boot_count_o)
  );

  always #5 clk_gen = ~clk_gen;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: synchronizers as delay queues, debouncer as a run length of
  // disagreeing samples, controller as spec-level state numbers 0..3.
  int q_lk[$], q_btn[$], q_bs[$], q_eff[$];
  int m_lvl, m_run, m_db, m_db_prev, m_st, m_hold, m_bs, m_eff, m_cnt, m_exit, m_blink;

  task automatic model_reset();
    q_lk.delete(); q_btn.delete(); q_bs.delete(); q_eff.delete();
    for (int i = 0; i < SYNC; i++) begin
      q_lk.push_back(0); q_btn.push_back(0); q_bs.push_back(0); q_eff.push_back(0);
    end
    m_lvl = 0; m_run = 0; m_db = 0; m_db_prev = 0; m_st = 0; m_hold = 0;
    m_bs = 0; m_eff = 0; m_cnt = 0; m_exit = 0; m_blink = 0; cyc = 0;
  endtask

  task automatic model_step();
    int s_lk, s_btn, s_bs, s_eff, nst, rise, lvl_old;
    s_lk  = q_lk.pop_back();  q_lk.push_front(int'(locked_i));
    s_btn = q_btn.pop_back(); q_btn.push_front(int'(rst_btn_i));
    s_bs  = q_bs.pop_back();  q_bs.push_front(int'(boot_select_i));
    s_eff = q_eff.pop_back(); q_eff.push_front(int'(execute_from_flash_i));
    rise = (m_db == 1 && m_db_prev == 0) ? 1 : 0;
    nst = m_st;
    if (m_st != 0 && s_lk == 0) nst = 0;
    else if (m_st == 0 && s_lk == 1) nst = 1;
    else if (m_st == 1 && m_db == 0 && m_hold == HOLD - 1) nst = 2;
    else if (m_st == 2 && rise == 1) nst = 1;
    else if (m_st == 2 && exit_valid_i) nst = 3;
    else if (m_st == 3 && rise == 1) nst = 1;
    if (m_st == 1 && nst == 2) begin
      m_bs = s_bs; m_eff = s_eff;
      if (m_cnt < 255) m_cnt++;
    end
    if (nst == 3 && m_st != 3) m_exit = int'(exit_value_i[0]);
    else if (nst != 3) m_exit = 0;
    m_hold = (m_st == 1 && m_db == 0) ? m_hold + 1 : 0;
    lvl_old = m_lvl;
    if (s_btn != m_lvl) begin
      m_run++;
      if (m_run == DEB) begin m_lvl = s_btn; m_run = 0; end
    end else begin
      m_run = 0;
    end
    m_db_prev = m_db;
    m_db = lvl_old;
    m_st = nst;
    m_blink = (m_blink + 1) % (1 << BW);
    cyc++;
  endtask

  function automatic int exp_led();
    case (m_st)
      0: return 0;
      1: return 1;
      2: return (m_blink >> (BW - 1)) & 1;
      default: return (m_exit != 0) ? ((m_blink >> (BW - 3)) & 1) : 1;
    endcase
  endfunction

  initial begin : model
    model_reset();
    forever begin
      @(posedge clk_gen);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk_gen);
      if (rst_n) begin
        check("state", state_o, m_st);
        check("sys_rst_no", sys_rst_no, (m_st >= 2) ? 1 : 0);
        check("done", done_o, (m_st == 3) ? 1 : 0);
        check("exit_bit", exit_bit_o, m_exit);
        check("status_led", status_led_o, exp_led());
        check("boot_select", boot_select_o, m_bs);
        check("exec_flash", execute_from_flash_o, m_eff);
        check("boot_count", boot_count_o, m_cnt);
      end
    end
  end

  // cycle n = n clock edges since reset release; returns at the negedge after edge n
  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk_gen);
  endtask

  task automatic wait_run(input int limit);
    int k = 0;
    while (state_o != 2'd2 && k < limit) begin
      @(negedge clk_gen);
      k++;
    end
    check("wait_run_timeout", state_o, 2);
  endtask

  initial begin : stim
    int prev, toggles, btn_left, lk_left;
    repeat (4) @(negedge clk_gen);
    check("rst_state", state_o, 0);
    check("rst_sys_rst_no", sys_rst_no, 0);
    check("rst_led", status_led_o, 0);
    check("rst_done", done_o, 0);
    check("rst_exit_bit", exit_bit_o, 0);
    check("rst_boot_select", boot_select_o, 0);
    check("rst_exec_flash", execute_from_flash_o, 0);
    check("rst_boot_count", boot_count_o, 0);
    rst_n = 1'b1;

    // lock rise sampled at edge 50
    at_cyc(30);
    check("prelock_sys_rst", sys_rst_no, 0);
    check("prelock_led", status_led_o, 0);
    at_cyc(49);
    locked_i = 1'b1; boot_select_i = 1'b1; execute_from_flash_i = 1'b0;
    at_cyc(51); check("lock_state51", state_o, 0);
    at_cyc(52); check("lock_state52", state_o, 1); check("hold_led", status_led_o, 1);
    at_cyc(115); check("hold_sys_rst115", sys_rst_no, 0);
    at_cyc(116); check("run_sys_rst116", sys_rst_no, 1); check("run_count1", boot_count_o, 1);
    check("strap_bs_run", boot_select_o, 1); check("strap_eff_run", execute_from_flash_o, 0);
    at_cyc(120); boot_select_i = 1'b0; execute_from_flash_i = 1'b1;
    at_cyc(130); check("strap_bs_hold", boot_select_o, 1); check("strap_eff_hold", execute_from_flash_o, 0);

    // 5-cycle glitch
    at_cyc(139); rst_btn_i = 1'b1;
    at_cyc(144); rst_btn_i = 1'b0;
    at_cyc(170); check("glitch_ignored", state_o, 2);

    // passing exit
    at_cyc(179); exit_valid_i = 1'b1; exit_value_i = $urandom() & 32'hFFFF_FFFE;
    at_cyc(180); exit_valid_i = 1'b0;
    check("pass_state", state_o, 3); check("pass_done", done_o, 1);
    check("pass_led", status_led_o, 1); check("pass_exit_bit", exit_bit_o, 0);

    // 30-cycle press sampled from edge 200
    at_cyc(199); rst_btn_i = 1'b1;
    at_cyc(210); check("press_state210", state_o, 3);
    at_cyc(211); check("press_state211", state_o, 1); check("press_sys_rst", sys_rst_no, 0);
    at_cyc(229); rst_btn_i = 1'b0;
    at_cyc(303); check("release_sys_rst303", sys_rst_no, 0);
    at_cyc(304); check("release_sys_rst304", sys_rst_no, 1);
    check("strap_bs_new", boot_select_o, 0); check("strap_eff_new", execute_from_flash_o, 1);
    check("run_count2", boot_count_o, 2);

    // failing exit: fast blink on bit BW-3
    at_cyc(319); exit_valid_i = 1'b1; exit_value_i = $urandom() | 32'h1;
    at_cyc(320); exit_valid_i = 1'b0;
    check("fail_state", state_o, 3); check("fail_exit_bit", exit_bit_o, 1);
    prev = int'(status_led_o); toggles = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_gen);
      check("fail_blink", status_led_o, (cyc >> 3) & 1);
      if (int'(status_led_o) != prev) toggles++;
      prev = int'(status_led_o);
    end
    check("fail_blink_toggles", toggles, 4);
    at_cyc(359); exit_valid_i = 1'b1; exit_value_i = 32'h0;
    at_cyc(361); exit_valid_i = 1'b0;
    check("done_ignores_exit", exit_bit_o, 1);

    // lock loss in DONE with a simultaneous button press
    at_cyc(369); locked_i = 1'b0; rst_btn_i = 1'b1;
    at_cyc(372);
    check("lockloss_state", state_o, 0); check("lockloss_sys_rst", sys_rst_no, 0);
    check("lockloss_done", done_o, 0); check("lockloss_led", status_led_o, 0);
    at_cyc(399); rst_btn_i = 1'b0;
    at_cyc(420); check("lockloss_btn_ignored", state_o, 0);
    at_cyc(429); locked_i = 1'b1;
    at_cyc(496); check("relock_run", state_o, 2); check("run_count3", boot_count_o, 3);

    // randomized traffic
    btn_left = 0; lk_left = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_gen);
      if (btn_left == 0) begin
        rst_btn_i = ~rst_btn_i;
        btn_left = rst_btn_i ? $urandom_range(1, 20) : $urandom_range(10, 300);
      end else begin
        btn_left--;
      end
      if (lk_left > 0) begin
        lk_left--;
        if (lk_left == 0) locked_i = 1'b1;
      end else if ($urandom_range(0, 999) < 3) begin
        locked_i = 1'b0;
        lk_left = $urandom_range(1, 12);
      end
      exit_valid_i = ($urandom_range(0, 99) < 4);
      exit_value_i = $urandom();
      if ($urandom_range(0, 49) == 0) begin
        boot_select_i = 1'($urandom_range(0, 1));
        execute_from_flash_i = 1'($urandom_range(0, 1));
      end
    end
    rst_btn_i = 1'b0; locked_i = 1'b1; exit_valid_i = 1'b0;
    wait_run(400);

    // saturation of the boot counter
    for (int i = 0; i < 300; i++) begin
      rst_btn_i = 1'b1;
      repeat (14) @(negedge clk_gen);
      rst_btn_i = 1'b0;
      repeat (5) @(negedge clk_gen);
      wait_run(200);
      if (state_o != 2'd2) break;
    end
    check("boot_count_saturated", boot_count_o, 255);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
